// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared types for ROB mispredict recovery: ROB entry layout, recovery FSM
// states and wrap-around index helpers.
package rob_recovery_ctrl_pkg;

    localparam int unsigned PREG_W = 7;
    localparam int unsigned ARCH_W = 5;

    typedef struct packed {
        logic              has_dest;
        logic [ARCH_W-1:0] arch_rd;
        logic [PREG_W-1:0] dest_preg;
        logic [PREG_W-1:0] old_preg;
    } rob_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } recov_state_e;

    // Step one slot older in a circular buffer of the given depth.
    function automatic int unsigned rob_idx_dec(input int unsigned idx, input int unsigned depth);
        return (idx == 0) ? depth - 1 : idx - 1;
    endfunction

    // Step one slot younger in a circular buffer of the given depth.
    function automatic int unsigned rob_idx_inc(input int unsigned idx, input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rob_recovery_ctrl.sv
// Branch-mispredict recovery sequencer. Walks squashed ROB entries
// youngest-first, one per cycle, restoring the speculative map and freeing
// destination pregs, then rewinds the ROB tail.
//
// state | meaning
// IDLE  | accepting flushes; free port carries commit-stage frees
// WALK  | one squashed entry per cycle at ptr; commit and rename held
// DONE  | tail rewind strobe; back to IDLE next cycle
module rob_recovery_ctrl
    import rob_recovery_ctrl_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_req_i,
    input  logic [IDX_W-1:0]  flush_rob_idx_i,
    output logic              flush_ready_o,
    input  logic [IDX_W-1:0]  rob_tail_i,
    output logic [IDX_W-1:0]  walk_rd_idx_o,
    input  rob_entry_t        walk_rd_entry_i,
    input  logic              commit_free_valid_i,
    input  logic [PREG_W-1:0] commit_free_preg_i,
    output logic              free_valid_o,
    output logic [PREG_W-1:0] free_preg_o,
    output logic              spec_map_wr_valid_o,
    output logic [4:0]        spec_map_wr_rd_o,
    output logic [PREG_W-1:0] spec_map_wr_preg_o,
    output logic              commit_hold_o,
    output logic              rename_stall_o,
    output logic              rob_tail_set_valid_o,
    output logic [IDX_W-1:0]  rob_tail_set_idx_o,
    output logic              busy_o
);

    recov_state_e     state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cnt;
    logic [IDX_W-1:0] flush_idx;
    logic [IDX_W-1:0] n_squash;

    // Entries strictly younger than the flushed one; exact even for a full ROB.
    assign n_squash = rob_tail_i - flush_rob_idx_i - IDX_W'(1);

    // Recovery FSM with registered busy and tail-rewind strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state                <= IDLE;
            ptr                  <= '0;
            cnt                  <= '0;
            flush_idx            <= '0;
            busy_o               <= 1'b0;
            rob_tail_set_valid_o <= 1'b0;
            rob_tail_set_idx_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req_i) begin
                        flush_idx <= flush_rob_idx_i;
                        busy_o    <= 1'b1;
                        if (n_squash == '0) begin
                            state                <= DONE;
                            rob_tail_set_valid_o <= 1'b1;
                            rob_tail_set_idx_o   <= IDX_W'(rob_idx_inc(32'(flush_rob_idx_i), DEPTH));
                        end else begin
                            state <= WALK;
                            ptr   <= IDX_W'(rob_idx_dec(32'(rob_tail_i), DEPTH));
                            cnt   <= {1'b0, n_squash};
                        end
                    end
                end
                WALK: begin
                    ptr <= IDX_W'(rob_idx_dec(32'(ptr), DEPTH));
                    cnt <= cnt - (IDX_W+1)'(1);
                    if (cnt == (IDX_W+1)'(1)) begin
                        state                <= DONE;
                        rob_tail_set_valid_o <= 1'b1;
                        rob_tail_set_idx_o   <= IDX_W'(rob_idx_inc(32'(flush_idx), DEPTH));
                    end
                end
                DONE: begin
                    state                <= IDLE;
                    busy_o               <= 1'b0;
                    rob_tail_set_valid_o <= 1'b0;
                    rob_tail_set_idx_o   <= '0;
                end
                default: begin
                    state                <= IDLE;
                    busy_o               <= 1'b0;
                    rob_tail_set_valid_o <= 1'b0;
                    rob_tail_set_idx_o   <= '0;
                end
            endcase
        end
    end

    assign flush_ready_o  = (state == IDLE);
    assign commit_hold_o  = busy_o | flush_req_i;
    assign rename_stall_o = busy_o;

    // Walk read/restore and the single free-list port: commit frees in IDLE, walk frees in WALK.
    always_comb begin
        walk_rd_idx_o       = '0;
        spec_map_wr_valid_o = 1'b0;
        spec_map_wr_rd_o    = '0;
        spec_map_wr_preg_o  = '0;
        free_valid_o        = 1'b0;
        free_preg_o         = '0;
        case (state)
            IDLE: begin
                if (commit_free_valid_i) begin
                    free_valid_o = 1'b1;
                    free_preg_o  = commit_free_preg_i;
                end
            end
            WALK: begin
                walk_rd_idx_o = ptr;
                if (walk_rd_entry_i.has_dest) begin
                    spec_map_wr_valid_o = 1'b1;
                    spec_map_wr_rd_o    = walk_rd_entry_i.arch_rd;
                    spec_map_wr_preg_o  = walk_rd_entry_i.old_preg;
                    // p0 is never allocated, so it is never returned.
                    if (walk_rd_entry_i.dest_preg != '0) begin
                        free_valid_o = 1'b1;
                        free_preg_o  = walk_rd_entry_i.dest_preg;
                    end
                end
            end
            default: ;
        endcase
    end

    // Commit must not issue frees while recovery owns the free port.
    assert property (@(posedge clk_i) disable iff (!rst_i)
                     !(commit_free_valid_i && state != IDLE));

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Scoreboard bench for rob_recovery_ctrl: expected per-cycle output records
// are queued when a flush is driven and compared at the falling edge.
module tb_rob_recovery_ctrl;
    import rob_recovery_ctrl_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDX_W = 4;

    typedef struct packed {
        logic [3:0]        rd_idx;
        logic              map_v;
        logic [4:0]        map_rd;
        logic [PREG_W-1:0] map_preg;
        logic              free_v;
        logic [PREG_W-1:0] free_preg;
        logic              hold;
        logic              stall;
        logic              busy;
        logic              ready;
        logic              tail_v;
        logic [3:0]        tail_idx;
    } obs_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              flush_req_i = 1'b0;
    logic [IDX_W-1:0]  flush_rob_idx_i = '0;
    logic              flush_ready_o;
    logic [IDX_W-1:0]  rob_tail_i = '0;
    logic [IDX_W-1:0]  walk_rd_idx_o;
    rob_entry_t        walk_rd_entry_i;
    logic              commit_free_valid_i = 1'b0;
    logic [PREG_W-1:0] commit_free_preg_i = '0;
    logic              free_valid_o;
    logic [PREG_W-1:0] free_preg_o;
    logic              spec_map_wr_valid_o;
    logic [4:0]        spec_map_wr_rd_o;
    logic [PREG_W-1:0] spec_map_wr_preg_o;
    logic              commit_hold_o;
    logic              rename_stall_o;
    logic              rob_tail_set_valid_o;
    logic [IDX_W-1:0]  rob_tail_set_idx_o;
    logic              busy_o;

    rob_entry_t rob_mem [DEPTH];
    obs_t       sb_q [$];
    obs_t       exp_r;
    obs_t       obs_r;
    int         n_checks = 0;
    int         n_errors = 0;

    rob_recovery_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_req_i         (flush_req_i),
        .flush_rob_idx_i     (flush_rob_idx_i),
        .flush_ready_o       (flush_ready_o),
        .rob_tail_i          (rob_tail_i),
        .walk_rd_idx_o       (walk_rd_idx_o),
        .walk_rd_entry_i     (walk_rd_entry_i),
        .commit_free_valid_i (commit_free_valid_i),
        .commit_free_preg_i  (commit_free_preg_i),
        .free_valid_o        (free_valid_o),
        .free_preg_o         (free_preg_o),
        .spec_map_wr_valid_o (spec_map_wr_valid_o),
        .spec_map_wr_rd_o    (spec_map_wr_rd_o),
        .spec_map_wr_preg_o  (spec_map_wr_preg_o),
        .commit_hold_o       (commit_hold_o),
        .rename_stall_o      (rename_stall_o),
        .rob_tail_set_valid_o(rob_tail_set_valid_o),
        .rob_tail_set_idx_o  (rob_tail_set_idx_o),
        .busy_o              (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Same-cycle ROB read
    assign walk_rd_entry_i = rob_mem[walk_rd_idx_o];

    function automatic obs_t sample_obs();
        obs_t r;
        r.rd_idx    = walk_rd_idx_o;
        r.map_v     = spec_map_wr_valid_o;
        r.map_rd    = spec_map_wr_rd_o;
        r.map_preg  = spec_map_wr_preg_o;
        r.free_v    = free_valid_o;
        r.free_preg = free_preg_o;
        r.hold      = commit_hold_o;
        r.stall     = rename_stall_o;
        r.busy      = busy_o;
        r.ready     = flush_ready_o;
        r.tail_v    = rob_tail_set_valid_o;
        r.tail_idx  = rob_tail_set_idx_o;
        return r;
    endfunction

    function automatic obs_t idle_rec(input logic req, input logic cfv, input logic [PREG_W-1:0] cfp);
        obs_t r = '0;
        r.ready     = 1'b1;
        r.hold      = req;
        r.free_v    = cfv;
        r.free_preg = cfv ? cfp : '0;
        return r;
    endfunction

    function automatic rob_entry_t mk(input logic hd, input logic [4:0] rd,
                                      input logic [PREG_W-1:0] dst, input logic [PREG_W-1:0] old);
        rob_entry_t e;
        e.has_dest  = hd;
        e.arch_rd   = rd;
        e.dest_preg = dst;
        e.old_preg  = old;
        return e;
    endfunction

    // Expected records: acceptance cycle, N walk cycles, tail-rewind cycle.
    task automatic push_flush(input logic [3:0] tail, input logic [3:0] fidx);
        logic [3:0] n;
        logic [3:0] idx;
        rob_entry_t e;
        obs_t       r;
        n = tail - fidx - 4'd1;
        sb_q.push_back(idle_rec(1'b1, 1'b0, '0));
        for (int i = 0; i < int'(n); i++) begin
            idx = tail - 4'(i + 1);
            e   = rob_mem[idx];
            r   = '0;
            r.rd_idx = idx;
            r.hold   = 1'b1;
            r.stall  = 1'b1;
            r.busy   = 1'b1;
            if (e.has_dest) begin
                r.map_v    = 1'b1;
                r.map_rd   = e.arch_rd;
                r.map_preg = e.old_preg;
                if (e.dest_preg != '0) begin
                    r.free_v    = 1'b1;
                    r.free_preg = e.dest_preg;
                end
            end
            sb_q.push_back(r);
        end
        r = '0;
        r.hold     = 1'b1;
        r.stall    = 1'b1;
        r.busy     = 1'b1;
        r.tail_v   = 1'b1;
        r.tail_idx = fidx + 4'd1;
        sb_q.push_back(r);
    endtask

    task automatic drive_flush(input logic [3:0] tail, input logic [3:0] fidx);
        flush_req_i     = 1'b1;
        rob_tail_i      = tail;
        flush_rob_idx_i = fidx;
        push_flush(tail, fidx);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        sb_q.push_back(idle_rec(1'b0, 1'b0, '0));
        while (sb_q.size() != 0) begin
            @(negedge clk_i);
            exp_r = sb_q.pop_front();
            obs_r = sample_obs();
            n_checks++;
            if (obs_r !== exp_r) begin
                n_errors++;
                $display("FAIL reset: got %h need %h", obs_r, exp_r);
            end
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic test_idle_passthrough();
        logic [PREG_W-1:0] pregs [3];
        logic              vals  [3];
        pregs = '{7'd23, 7'd5, 7'd0};
        vals  = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            commit_free_valid_i = vals[i];
            commit_free_preg_i  = pregs[i];
            @(negedge clk_i);
            exp_r = idle_rec(1'b0, vals[i], pregs[i]);
            obs_r = sample_obs();
            n_checks++;
            if (obs_r !== exp_r) begin
                n_errors++;
                $display("FAIL idle_passthrough[%0d]: got %h need %h", i, obs_r, exp_r);
            end
            @(posedge clk_i);
            #1;
        end
        commit_free_valid_i = 1'b0;
        commit_free_preg_i  = '0;
    endtask

    task automatic test_basic_walk();
        rob_mem[8] = mk(1'b1, 5'd3, 7'd40, 7'd12);
        rob_mem[7] = mk(1'b1, 5'd4, 7'd41, 7'd13);
        rob_mem[6] = mk(1'b1, 5'd3, 7'd42, 7'd40);
        rob_mem[5] = mk(1'b1, 5'd9, 7'd99, 7'd98);
        drive_flush(4'd9, 4'd5);
        sb_q.push_back(idle_rec(1'b0, 1'b0, '0));
        for (int k = 0; sb_q.size() != 0; k++) begin
            @(negedge clk_i);
            exp_r = sb_q.pop_front();
            obs_r = sample_obs();
            n_checks++;
            if (obs_r !== exp_r) begin
                n_errors++;
                $display("FAIL basic_walk cyc%0d: got %h need %h", k, obs_r, exp_r);
            end
            @(posedge clk_i);
            #1;
            flush_req_i = 1'b0;
        end
    endtask

    task automatic test_wrap();
        rob_mem[1]  = mk(1'b1, 5'd1, 7'd50, 7'd20);
        rob_mem[0]  = mk(1'b1, 5'd2, 7'd51, 7'd21);
        rob_mem[15] = mk(1'b1, 5'd30, 7'd52, 7'd22);
        rob_mem[14] = mk(1'b1, 5'd31, 7'd127, 7'd23);
        rob_mem[13] = mk(1'b1, 5'd8, 7'd60, 7'd61);
        drive_flush(4'd2, 4'd13);
        sb_q.push_back(idle_rec(1'b0, 1'b0, '0));
        for (int k = 0; sb_q.size() != 0; k++) begin
            @(negedge clk_i);
            exp_r = sb_q.pop_front();
            obs_r = sample_obs();
            n_checks++;
            if (obs_r !== exp_r) begin
                n_errors++;
                $display("FAIL wrap cyc%0d: got %h need %h", k, obs_r, exp_r);
            end
            @(posedge clk_i);
            #1;
            flush_req_i = 1'b0;
        end
    endtask

    task automatic test_empty_squash();
        drive_flush(4'd6, 4'd5);
        sb_q.push_back(idle_rec(1'b0, 1'b0, '0));
        for (int k = 0; sb_q.size() != 0; k++) begin
            @(negedge clk_i);
            exp_r = sb_q.pop_front();
            obs_r = sample_obs();
            n_checks++;
            if (obs_r !== exp_r) begin
                n_errors++;
                $display("FAIL empty_squash cyc%0d: got %h need %h", k, obs_r, exp_r);
            end
            @(posedge clk_i);
            #1;
            flush_req_i = 1'b0;
        end
    endtask

    task automatic test_mixed();
        rob_mem[11] = mk(1'b0, 5'd6, 7'd33, 7'd34);
        rob_mem[10] = mk(1'b1, 5'd7, 7'd0, 7'd17);
        rob_mem[9]  = mk(1'b1, 5'd12, 7'd70, 7'd71);
        drive_flush(4'd12, 4'd8);
        sb_q.push_back(idle_rec(1'b0, 1'b0, '0));
        for (int k = 0; sb_q.size() != 0; k++) begin
            @(negedge clk_i);
            exp_r = sb_q.pop_front();
            obs_r = sample_obs();
            n_checks++;
            if (obs_r !== exp_r) begin
                n_errors++;
                $display("FAIL mixed cyc%0d: got %h need %h", k, obs_r, exp_r);
            end
            @(posedge clk_i);
            #1;
            flush_req_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_walk();
        rob_mem[13] = mk(1'b1, 5'd13, 7'd80, 7'd81);
        rob_mem[12] = mk(1'b1, 5'd14, 7'd82, 7'd83);
        rob_mem[11] = mk(1'b1, 5'd15, 7'd84, 7'd85);
        rob_mem[10] = mk(1'b1, 5'd16, 7'd86, 7'd87);
        drive_flush(4'd14, 4'd9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            exp_r = sb_q.pop_front();
            obs_r = sample_obs();
            n_checks++;
            if (obs_r !== exp_r) begin
                n_errors++;
                $display("FAIL reset_mid_walk cyc%0d: got %h need %h", k, obs_r, exp_r);
            end
            @(posedge clk_i);
            #1;
            flush_req_i = 1'b0;
            if (k == 1) rst_i = 1'b0;
        end
        sb_q.delete();
        rst_i = 1'b1;
        drive_flush(4'd6, 4'd5);
        sb_q.push_back(idle_rec(1'b0, 1'b0, '0));
        for (int k = 3; sb_q.size() != 0; k++) begin
            @(negedge clk_i);
            exp_r = sb_q.pop_front();
            obs_r = sample_obs();
            n_checks++;
            if (obs_r !== exp_r) begin
                n_errors++;
                $display("FAIL reset_mid_walk cyc%0d: got %h need %h", k, obs_r, exp_r);
            end
            @(posedge clk_i);
            #1;
            flush_req_i = 1'b0;
        end
    endtask

    // Second request is held through the first recovery and accepted in the first IDLE cycle.
    task automatic test_back_to_back();
        rob_mem[2] = mk(1'b1, 5'd20, 7'd90, 7'd91);
        rob_mem[1] = mk(1'b1, 5'd21, 7'd92, 7'd93);
        drive_flush(4'd9, 4'd5);
        push_flush(4'd3, 4'd0);
        sb_q.push_back(idle_rec(1'b0, 1'b0, '0));
        for (int k = 0; sb_q.size() != 0; k++) begin
            @(negedge clk_i);
            exp_r = sb_q.pop_front();
            obs_r = sample_obs();
            n_checks++;
            if (obs_r !== exp_r) begin
                n_errors++;
                $display("FAIL back_to_back cyc%0d: got %h need %h", k, obs_r, exp_r);
            end
            @(posedge clk_i);
            #1;
            rob_tail_i      = 4'd3;
            flush_rob_idx_i = 4'd0;
            if (k >= 5) flush_req_i = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) rob_mem[i] = '0;
        test_reset();
        test_idle_passthrough();
        test_basic_walk();
        test_wrap();
        test_empty_squash();
        test_mixed();
        test_reset_mid_walk();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
